// File: rtl/reg_access_if.sv
// Instruction handshake plus register-file port bundle for reg_access_ctrl.
// The slave modport is the controller; the master side is the instruction source and register file.
interface reg_access_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [1:0] rf_read_reg1;
  logic [1:0] rf_read_reg2;
  logic [7:0] rf_read_data1;
  logic [7:0] rf_read_data2;
  logic       rf_write;
  logic [1:0] rf_write_reg;
  logic [7:0] rf_write_data;
  logic       done;
  logic [7:0] result;
  logic       zero;

  modport slave (
    input  instr_valid, instr, rf_read_data1, rf_read_data2,
    output instr_ready, rf_read_reg1, rf_read_reg2,
           rf_write, rf_write_reg, rf_write_data, done, result, zero
  );

  modport master (
    output instr_valid, instr, rf_read_data1, rf_read_data2,
    input  instr_ready, rf_read_reg1, rf_read_reg2,
           rf_write, rf_write_reg, rf_write_data, done, result, zero
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Four-state register-access controller: accept, read operands, compute, write back.
// One instruction per four cycles; the write-back completes before the next operand read.
module reg_access_ctrl (
  input  logic          clk,
  input  logic          reset,
  reg_access_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, READ, CAPT, WB} state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  state_e     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic       rf_write_q, rf_write_d;
  logic [1:0] rf_write_reg_q, rf_write_reg_d;
  logic [7:0] rf_write_data_q, rf_write_data_d;
  logic       done_q, done_d;
  logic [7:0] result_q, result_d;
  logic       zero_q, zero_d;
  logic [7:0] alu;

  // Operands are the register-file read data, valid during CAPT.
  always_comb begin
    alu = 8'h00;
    case (instr_q[7:6])
      OP_ADD:  alu = bus.rf_read_data1 + bus.rf_read_data2;
      OP_SUB:  alu = bus.rf_read_data1 - bus.rf_read_data2;
      OP_AND:  alu = bus.rf_read_data1 & bus.rf_read_data2;
      default: alu = {4'b0000, instr_q[3:0]};
    endcase
  end

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    rf_write_d      = 1'b0;
    done_d          = 1'b0;
    rf_write_reg_d  = rf_write_reg_q;
    rf_write_data_d = rf_write_data_q;
    result_d        = result_q;
    zero_d          = zero_q;
    case (state_q)
      IDLE: if (bus.instr_valid) begin
        instr_d = bus.instr;
        state_d = READ;
      end
      READ: state_d = CAPT;
      CAPT: begin
        rf_write_d      = 1'b1;
        done_d          = 1'b1;
        rf_write_reg_d  = instr_q[5:4];
        rf_write_data_d = alu;
        result_d        = alu;
        zero_d          = (alu == 8'h00);
        state_d         = WB;
      end
      default: state_d = IDLE;
    endcase
  end

  // Async reset also kills a pending write while in WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      instr_q         <= 8'h00;
      rf_write_q      <= 1'b0;
      rf_write_reg_q  <= 2'b00;
      rf_write_data_q <= 8'h00;
      done_q          <= 1'b0;
      result_q        <= 8'h00;
      zero_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      rf_write_q      <= rf_write_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
      done_q          <= done_d;
      result_q        <= result_d;
      zero_q          <= zero_d;
    end
  end

  assign bus.instr_ready   = (state_q == IDLE);
  assign bus.rf_read_reg1  = instr_q[3:2];
  assign bus.rf_read_reg2  = instr_q[1:0];
  assign bus.rf_write      = rf_write_q;
  assign bus.rf_write_reg  = rf_write_reg_q;
  assign bus.rf_write_data = rf_write_data_q;
  assign bus.done          = done_q;
  assign bus.result        = result_q;
  assign bus.zero          = zero_q;
endmodule
